// File: rtl/program_loader.sv
// Boot loader: length-prefixed little-endian byte stream -> instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam logic [16:0] CAP = 17'(2 ** ADDR_WIDTH);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_HDR_LO, S_HDR_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_e;
    localparam state_e S_FINISH = S_CHECK;
`else
    typedef enum logic [2:0] {
        S_HDR_LO, S_HDR_HI, S_DATA, S_DONE, S_ERROR
    } state_e;
    localparam state_e S_FINISH = S_DONE;
`endif

    state_e                state_q, state_d;
    logic                  rdy_q, rdy_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [23:0]           buf_q, buf_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
`endif

    logic        accept;
    logic [16:0] hdr;
    logic        last_word;

    assign accept    = rx_valid & rdy_q;
    assign hdr       = {1'b0, rx_data, cnt_q[7:0]};
    assign last_word = (17'(words_q) + 17'd1) == {1'b0, cnt_q};

    // Next-state and datapath: header parse, byte packing, hold release
    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        buf_d   = buf_q;
`ifdef LOADER_CHECKSUM_EN
        xor_d   = xor_q;
        if (accept) xor_d = xor_q ^ rx_data;
`endif
        unique case (state_q)
            S_HDR_LO: begin
                if (accept) begin
                    cnt_d[7:0] = rx_data;
                    state_d    = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    cnt_d[15:8] = rx_data;
                    if (hdr == 17'd0)  state_d = S_FINISH;
                    else if (hdr > CAP) state_d = S_ERROR;
                    else                state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = words_q[ADDR_WIDTH-1:0];
                        wdata_d = {rx_data, buf_q};
                        words_d = words_q + 1'b1;
                        if (last_word) state_d = S_FINISH;
                    end else begin
                        buf_d = {rx_data, buf_q[23:8]};
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE: begin
                hold_d = 1'b0;
            end
            S_ERROR: begin
                hold_d = 1'b1;
            end
            default: begin
                state_d = S_HDR_LO;
            end
        endcase
        if (restart && (state_q == S_DONE || state_q == S_ERROR)) begin
            state_d = S_HDR_LO;
            hold_d  = 1'b1;
            words_d = '0;
            cnt_d   = '0;
            bidx_d  = '0;
            buf_d   = '0;
`ifdef LOADER_CHECKSUM_EN
            xor_d   = '0;
`endif
        end
        rdy_d = (state_d != S_DONE) && (state_d != S_ERROR);
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_HDR_LO;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            words_q <= '0;
            cnt_q   <= '0;
            bidx_q  <= '0;
            buf_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            buf_q   <= buf_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign rx_ready     = rdy_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign core_hold    = hold_q;
    assign done         = (state_q == S_DONE);
    assign error        = (state_q == S_ERROR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: stream model plus per-cycle write checker.
// Builds with or without LOADER_CHECKSUM_EN.
module tb_program_loader;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic          restart = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .restart(restart),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_hold(core_hold), .done(done), .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [31:0] mem [1024];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    int          exp_words;
    bit          exp_done;
    bit          exp_err;

    always @(posedge clk) if (imem_we) mem[imem_addr] <= imem_wdata;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Model: derive expected writes and final status from the stream alone.
    task automatic model_load(input logic [7:0] s[$]);
        int cnt;
        logic [7:0] x;
        cnt = int'({s[1], s[0]});
        exp_done  = 1'b0;
        exp_err   = 1'b0;
        exp_words = 0;
        if (cnt > 2 ** AW) begin
            exp_err = 1'b1;
            return;
        end
        for (int w = 0; w < cnt; w++) begin
            exp_addr.push_back(32'(w));
            exp_data.push_back({s[2+4*w+3], s[2+4*w+2],
                                s[2+4*w+1], s[2+4*w]});
        end
        exp_words = cnt;
        x = 8'h00;
        for (int i = 0; i < 2 + 4 * cnt; i++) x = x ^ s[i];
`ifdef LOADER_CHECKSUM_EN
        if (s[2+4*cnt] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
`else
        exp_done = 1'b1;
`endif
    endtask

    // Per-cycle checker: every write must match the model, in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                if (exp_addr.size() == 0) begin
                    tot_cnt++;
                    $display("FAIL unexpected_write: addr %h data %h",
                             imem_addr, imem_wdata);
                end else begin
                    chk("wr_addr", 32'(imem_addr), exp_addr.pop_front());
                    chk("wr_data", imem_wdata, exp_data.pop_front());
                end
            end
            if (done || error) chk("rdy_idle", 32'(rx_ready), 32'd0);
            if (!done) chk("hold_until_done", 32'(core_hold), 32'd1);
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) begin
            tot_cnt++;
            $display("FAIL send_timeout: byte %h rx_ready %b expected 1",
                     b, rx_ready);
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic run_stream(input logic [7:0] s[$], input bit thr);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (thr) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        if (!thr) begin
            chk("done_at_end", 32'(done), 32'(exp_done));
            chk("err_at_end", 32'(error), 32'(exp_err));
        end
        repeat (3) @(negedge clk);
        chk("done", 32'(done), 32'(exp_done));
        chk("error", 32'(error), 32'(exp_err));
        chk("words", 32'(words_loaded), 32'(exp_words));
        chk("hold", 32'(core_hold), 32'(!exp_done));
        chk("rdy_end", 32'(rx_ready), 32'd0);
        chk("writes_seen", 32'(exp_addr.size()), 32'd0);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("rst_hold", 32'(core_hold), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_rdy", 32'(rx_ready), 32'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdy"}, 32'(rx_ready), 32'd0);
        chk({tag, "_we"}, 32'(imem_we), 32'd0);
        chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
        chk({tag, "_wdata"}, imem_wdata, 32'd0);
        chk({tag, "_hold"}, 32'(core_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    logic [7:0] norm[$];
    logic [7:0] beef[$];
    logic [7:0] zero[$];
    logic [7:0] big[$];
    logic [7:0] part[$];

    initial begin
        norm = '{8'h02, 8'h00, 8'h93, 8'h80, 8'hA0,
                 8'h02, 8'h13, 8'hE1, 8'h50, 8'h01};
        beef = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        zero = '{8'h00, 8'h00};
        big  = '{8'h01, 8'h04};
        part = '{8'h02, 8'h00, 8'h93, 8'h80};
`ifdef LOADER_CHECKSUM_EN
        norm.push_back(8'h10);
        beef.push_back(8'h23);
        zero.push_back(8'h00);
`endif
        foreach (mem[i]) mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_after_reset", 32'(rx_ready), 32'd1);

        // Normal load, valid held high
        model_load(norm);
        run_stream(norm, 1'b0);
        chk("mem0", mem[0], 32'h02A08093);
        chk("mem1", mem[1], 32'h0150E113);

        // Restart into a one-word load
        pulse_restart();
        model_load(beef);
        run_stream(beef, 1'b0);
        chk("mem0_beef", mem[0], 32'hDEADBEEF);
        chk("words_beef", 32'(words_loaded), 32'd1);

        // Reset in the middle of the first word, then reload
        pulse_restart();
        foreach (part[i]) send_byte(part[i]);
        rx_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("midreset");
        reset = 1'b0;
        @(negedge clk);
        model_load(norm);
        run_stream(norm, 1'b0);
        chk("mem0_reload", mem[0], 32'h02A08093);

        // Restart wins over a simultaneous byte; then empty program
        rx_data  = 8'h05;
        rx_valid = 1'b1;
        pulse_restart();
        rx_valid = 1'b0;
        model_load(zero);
        run_stream(zero, 1'b0);
        chk("zero_words", 32'(words_loaded), 32'd0);

        // Oversized header aborts
        pulse_restart();
        model_load(big);
        run_stream(big, 1'b0);
        chk("big_err", 32'(error), 32'd1);

        // Throttled normal stream from ERROR
        pulse_restart();
        mem[0] = 32'h0;
        mem[1] = 32'h0;
        model_load(norm);
        run_stream(norm, 1'b1);
        chk("thr_mem0", mem[0], 32'h02A08093);
        chk("thr_mem1", mem[1], 32'h0150E113);

`ifdef LOADER_CHECKSUM_EN
        // Bad trailing checksum
        pulse_restart();
        norm[10] = 8'h11;
        model_load(norm);
        run_stream(norm, 1'b0);
        chk("cks_err", 32'(error), 32'd1);
        chk("cks_hold", 32'(core_hold), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
